// File: rtl/tdc_pkg.sv
// Shared types and default widths for the TDC coarse-capture stage.
package tdc_pkg;

    localparam int COARSE_W_DEF = 12;
    localparam int FINE_W_DEF   = 4;
    localparam int TS_W         = COARSE_W_DEF + FINE_W_DEF;

    // Timeout marker stamp: saturated coarse count, fine code cleared.
    localparam logic [TS_W-1:0] TS_SENTINEL = {{COARSE_W_DEF{1'b1}}, {FINE_W_DEF{1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tdc_state_e;

endpackage

// File: rtl/tdc_ts_fifo.sv
// Synchronous timestamp FIFO with extra-MSB pointers and a single-cycle flush.
module tdc_ts_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk5,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;
    logic             rd_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // A read in the same cycle frees the slot, so a full FIFO can still accept.
    assign wr_ok = wr_en && (!full || rd_en);
    assign rd_ok = rd_en && !empty;

    always_ff @(posedge clk5) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk5) begin
        if (wr_ok && !flush) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/tdc_coarse_capture.sv
// TDC coarse capture: rising-edge hit detection, coarse/fine stamping and FIFO readout.
// Optional feature macro: TDC_CAP_TIMEOUT_EN (push a sentinel stamp on window timeout).
module tdc_coarse_capture
    import tdc_pkg::*;
#(
    parameter int COARSE_W = COARSE_W_DEF,
    parameter int FINE_W   = FINE_W_DEF,
    parameter int DEPTH    = 4,
    parameter int MAX_HITS = 4
) (
    input  logic                          clk5,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          sync,
    input  logic [FINE_W-1:0]             fine_code,
    input  logic                          ts_ready,
    output logic                          ts_valid,
    output logic [COARSE_W+FINE_W-1:0]    ts_data,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(MAX_HITS+1)-1:0] hit_cnt
);

    localparam int STAMP_W = COARSE_W + FINE_W;
    localparam int CNT_W   = $clog2(MAX_HITS+1);
    localparam logic [COARSE_W-1:0] COARSE_MAX = '1;
    localparam logic [CNT_W-1:0]    LAST_CNT   = CNT_W'(MAX_HITS - 1);

    tdc_state_e          state;
    logic [COARSE_W-1:0] coarse;
    logic                sync_d;

    logic                fifo_empty;
    logic                fifo_full;
    logic [STAMP_W-1:0]  fifo_rd_data;
    logic                pop;
    logic                rearm;
    logic                hit;
    logic                hit_ok;
    logic                hit_drop;
    logic                last_hit;
    logic                timeout;
    logic                wr_en;
    logic [STAMP_W-1:0]  wr_data;
    logic                sent_ok;
    logic                sent_drop;

    assign pop      = !fifo_empty && ts_ready;
    assign rearm    = start && (state == RUN);
    assign hit      = sync && !sync_d && (state == RUN) && !start;
    assign hit_ok   = hit && (!fifo_full || pop);
    assign hit_drop = hit && fifo_full && !pop;
    assign last_hit = hit_ok && (hit_cnt == LAST_CNT);
    assign timeout  = (state == RUN) && !start && (coarse == COARSE_MAX);

`ifdef TDC_CAP_TIMEOUT_EN
    localparam logic [STAMP_W-1:0] SENTINEL_STAMP = {{COARSE_W{1'b1}}, {FINE_W{1'b0}}};

    // The timeout cycle may already be writing a hit, so the sentinel goes in
    // one cycle later, when the FSM is in IDLE and the write port is free.
    logic sent_pend;

    always_ff @(posedge clk5) begin
        if (rst) begin
            sent_pend <= 1'b0;
        end else begin
            sent_pend <= timeout && !last_hit;
        end
    end

    assign sent_ok   = sent_pend && !start && (!fifo_full || pop);
    assign sent_drop = sent_pend && !start && fifo_full && !pop;
    assign wr_data   = sent_pend ? SENTINEL_STAMP : {coarse, fine_code};
`else
    assign sent_ok   = 1'b0;
    assign sent_drop = 1'b0;
    assign wr_data   = {coarse, fine_code};
`endif

    assign wr_en = hit_ok || sent_ok;

    tdc_ts_fifo #(
        .WIDTH (STAMP_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk5    (clk5),
        .rst     (rst),
        .flush   (rearm),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign ts_valid = !fifo_empty;
    assign ts_data  = fifo_empty ? '0 : fifo_rd_data;

    always_ff @(posedge clk5) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            coarse   <= '0;
            sync_d   <= 1'b0;
            hit_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            sync_d <= sync;

            if (start) begin
                state    <= RUN;
                busy     <= 1'b1;
                coarse   <= '0;
                hit_cnt  <= '0;
                overflow <= 1'b0;
            end else begin
                if (hit_drop || sent_drop) overflow <= 1'b1;

                if (state == RUN) begin
                    if (hit_ok) hit_cnt <= hit_cnt + CNT_W'(1);
                    if (coarse != COARSE_MAX) coarse <= coarse + COARSE_W'(1);
                    if (last_hit || timeout) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tdc_coarse_capture.sv
// Randomised and directed checks of tdc_coarse_capture against a queue-based window model.
module tb_tdc_coarse_capture;

    localparam int CW    = 5;
    localparam int FW    = 4;
    localparam int DEP   = 4;
    localparam int MAXH  = 6;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int HCW   = $clog2(MAXH+1);

    logic              clk5 = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              sync = 1'b0;
    logic [FW-1:0]     fine_code = '0;
    logic              ts_ready = 1'b0;
    logic              ts_valid;
    logic [CW+FW-1:0]  ts_data;
    logic              busy;
    logic              overflow;
    logic [HCW-1:0]    hit_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    int   m_cyc = 0;
    int   m_win = 0;
    bit   m_run = 0;
    int   m_hits = 0;
    bit   m_ovf = 0;
    bit   m_prev = 0;
    bit   m_pend = 0;
    int   m_q[$];

    tdc_coarse_capture #(
        .COARSE_W (CW),
        .FINE_W   (FW),
        .DEPTH    (DEP),
        .MAX_HITS (MAXH)
    ) dut (
        .clk5      (clk5),
        .rst       (rst),
        .start     (start),
        .sync      (sync),
        .fine_code (fine_code),
        .ts_ready  (ts_ready),
        .ts_valid  (ts_valid),
        .ts_data   (ts_data),
        .busy      (busy),
        .overflow  (overflow),
        .hit_cnt   (hit_cnt)
    );

    always #5 clk5 = ~clk5;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Advance the reference model by one clock using the inputs of this cycle.
    task automatic model_step(input bit s, input bit sy, input int f, input bit r, input bit rs);
        bit popped;
        int c;
        m_cyc++;
        if (rs) begin
            m_run = 0; m_hits = 0; m_ovf = 0; m_pend = 0; m_prev = 0;
            m_q.delete();
            return;
        end
        popped = (m_q.size() > 0) && r;
        if (s) begin
            if (m_run) m_q.delete();
            else if (popped) void'(m_q.pop_front());
            m_run = 1; m_win = m_cyc; m_hits = 0; m_ovf = 0; m_pend = 0;
        end else begin
            if (popped) void'(m_q.pop_front());
            if (m_pend) begin
                m_pend = 0;
                if (m_q.size() < DEP) m_q.push_back(CMAX << FW);
                else m_ovf = 1;
            end
            if (m_run) begin
                c = m_cyc - m_win - 1;
                if (sy && !m_prev) begin
                    if (m_q.size() < DEP) begin
                        m_q.push_back((c << FW) | f);
                        m_hits++;
                    end else begin
                        m_ovf = 1;
                    end
                end
                if (m_hits == MAXH) begin
                    m_run = 0;
                end else if (c == CMAX) begin
                    m_run = 0;
`ifdef TDC_CAP_TIMEOUT_EN
                    m_pend = 1;
`endif
                end
            end
        end
        m_prev = sy;
    endtask

    task automatic step(input bit s, input bit sy, input int f, input bit r, input bit rs);
        rst = rs; start = s; sync = sy; fine_code = FW'(f); ts_ready = r;
        model_step(s, sy, f, r, rs);
        @(posedge clk5);
        #1;
        check_val("ts_valid", ts_valid, (m_q.size() > 0));
        if (m_q.size() > 0) check_val("ts_data", ts_data, m_q[0]);
        check_val("busy", busy, m_run);
        check_val("overflow", overflow, m_ovf);
        check_val("hit_cnt", hit_cnt, m_hits);
    endtask

    task automatic quiet(input int n, input bit r);
        for (int k = 0; k < n; k++) step(0, 0, 0, r, 0);
    endtask

    initial begin
        int sp;
        int rp;
        logic [CW+FW-1:0] held;

        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check_val("rst_valid", ts_valid, 0);
        check_val("rst_busy", busy, 0);

        // first stamp: start at cycle 0, sync rises at cycle 11 with fine 9
        step(1, 0, 0, 0, 0);
        quiet(10, 0);
        step(0, 1, 9, 0, 0);
        check_val("first_valid", ts_valid, 1);
        check_val("first_stamp", ts_data, {5'd10, 4'h9});
        step(0, 0, 0, 0, 0);
        quiet(8, 1);

        // run to MAX_HITS with ready high, then one extra pulse
        step(1, 0, 0, 1, 0);
        for (int k = 0; k < MAXH + 1; k++) begin
            step(0, 1, k, 1, 0);
            quiet(3, 1);
        end
        check_val("maxhit_busy", busy, 0);
        check_val("maxhit_cnt", hit_cnt, MAXH);

        // fill FIFO, then a hit coinciding with a pop must be accepted
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < DEP; k++) begin
            step(0, 1, k + 3, 0, 0);
            step(0, 0, 0, 0, 0);
        end
        step(0, 1, 7, 1, 0);
        check_val("pophit_ovf", overflow, 0);
        check_val("pophit_cnt", hit_cnt, DEP + 1);

        // re-arm mid-window, then overflow with ready held low
        step(1, 0, 0, 0, 0);
        check_val("rearm_flush", ts_valid, 0);
        for (int k = 0; k < DEP + 1; k++) begin
            step(0, 1, k, 0, 0);
            step(0, 0, 0, 0, 0);
        end
        check_val("ovf_flag", overflow, 1);
        check_val("ovf_cnt", hit_cnt, DEP);
        held = ts_data;
        quiet(3, 0);
        check_val("stall_stable", ts_data, held);
        quiet(6, 1);

        // reset in the middle of a window with stamps queued
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 2, 0, 0);
        step(0, 0, 0, 0, 1);
        check_val("midrst_valid", ts_valid, 0);
        check_val("midrst_busy", busy, 0);
        check_val("midrst_cnt", hit_cnt, 0);
        check_val("midrst_ovf", overflow, 0);

        // timeout with no hits
        step(1, 0, 0, 0, 0);
        quiet(CMAX + 4, 0);
        check_val("tmo_busy", busy, 0);
`ifdef TDC_CAP_TIMEOUT_EN
        check_val("tmo_sentinel_v", ts_valid, 1);
        check_val("tmo_sentinel_d", ts_data, {5'h1f, 4'h0});
`else
        check_val("tmo_no_stamp", ts_valid, 0);
`endif
        quiet(4, 1);

        // randomised phases with varying sync/ready activity
        for (int i = 0; i < 6000; i++) begin
            sp = 20 + 15 * ((i / 750) % 4);
            rp = ((i / 1000) % 3) * 45 + 5;
            step($urandom_range(0, 69) == 0,
                 $urandom_range(0, 99) < sp,
                 $urandom_range(0, (1 << FW) - 1),
                 $urandom_range(0, 99) < rp,
                 $urandom_range(0, 499) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
